// File: rtl/lms_pkg.sv
// Shared width, state encoding and LFSR / magnitude helpers for the LMS stimulus driver.
// Declarations only: no timing and no flow control of its own.
package lms_pkg;

  localparam int DATA_W = 8;

  // x^8 + x^6 + x^5 + x^4 + 1 expressed as feedback taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } lms_state_e;

  // Magnitude of a sign-extended sample, one bit wider so the most negative value stays exact.
  function automatic logic [32:0] abs_ext(input logic signed [31:0] v);
    logic signed [32:0] w;
    w = {v[31], v};
    return w[32] ? 33'(-w) : 33'(w);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Upper nibble of the register as a small signed sample, range -8..7
  function automatic logic signed [7:0] lfsr_sample(input logic [7:0] s);
    return $signed(s) >>> 4;
  endfunction

endpackage

// File: rtl/lms_lfsr8.sv
// 8-bit Fibonacci LFSR: seed loaded on reset or load, one step per cycle with adv; state is registered.
// No backpressure: advances whenever adv is high.
module lms_lfsr8
  import lms_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] lfsr_state
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_state <= SEED;
    end else if (adv) begin
      lfsr_state <= lfsr_step(lfsr_state);
    end
  end

endmodule

// File: rtl/lms_stim_driver.sv
// LMS stimulus source and convergence monitor; outputs registered, first sample one edge after start.
// No backpressure (one sample per cycle); LFSR_EN swaps the X_A/X_B pattern for a pseudo-random source.
module lms_stim_driver
  import lms_pkg::*;
#(
  parameter int DATA_W      = lms_pkg::DATA_W,
  parameter int X_A         = 2,
  parameter int X_B         = 1,
  parameter int ERR_TOL     = 1,
  parameter int CONV_COUNT  = 4,
  parameter int MAX_SAMPLES = 255
`ifdef LFSR_EN
  ,
  parameter logic [7:0] LFSR_SEED = 8'h5A
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     x_valid,
  input  logic signed [DATA_W-1:0] e_in,
  input  logic                     e_valid,
  output logic                     converged,
  output logic                     timeout,
  output logic                     busy,
  output logic [15:0]              sample_cnt
);

  localparam int                      OKW     = $clog2(CONV_COUNT + 1);
  localparam logic [OKW-1:0]          OK_MAX  = OKW'(CONV_COUNT);
  localparam logic [15:0]             CNT_MAX = 16'(MAX_SAMPLES);
  localparam logic signed [DATA_W-1:0] XA     = DATA_W'(X_A);
  localparam logic signed [DATA_W-1:0] XB     = DATA_W'(X_B);

  lms_state_e                state;
  logic [OKW-1:0]            ok_cnt;
  logic                      phase;

  logic [32:0]               e_mag;
  logic                      e_ok;
  logic [OKW-1:0]            ok_nxt;
  logic [15:0]               cnt_nxt;
  logic signed [DATA_W-1:0]  x_first;
  logic signed [DATA_W-1:0]  x_step;

`ifdef LFSR_EN
  logic [7:0] lfsr_q;

  lms_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .adv        (state == RUN),
    .lfsr_state (lfsr_q)
  );

  // x_out is registered, so the next sample is taken from the value the LFSR is about to hold
  assign x_first = DATA_W'(lfsr_sample(LFSR_SEED));
  assign x_step  = DATA_W'(lfsr_sample(lfsr_step(lfsr_q)));
`else
  assign x_first = XA;
  assign x_step  = phase ? XA : XB;
`endif

  always_comb begin
    e_mag   = abs_ext(32'(e_in));
    e_ok    = (e_mag <= 33'(ERR_TOL));
    ok_nxt  = ok_cnt;
    if (e_valid) begin
      if (!e_ok) begin
        ok_nxt = '0;
      end else if (ok_cnt != OK_MAX) begin
        ok_nxt = ok_cnt + OKW'(1);
      end
    end
    cnt_nxt = sample_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_out      <= '0;
      x_valid    <= 1'b0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      sample_cnt <= '0;
      ok_cnt     <= '0;
      phase      <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      x_out      <= x_first;
      x_valid    <= 1'b1;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b1;
      sample_cnt <= '0;
      ok_cnt     <= '0;
      phase      <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          sample_cnt <= cnt_nxt;
          ok_cnt     <= ok_nxt;
          phase      <= ~phase;
          // Convergence wins when both limits land on the same sample
          if (ok_nxt == OK_MAX) begin
            state     <= DONE;
            converged <= 1'b1;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt_nxt == CNT_MAX) begin
            state   <= TOUT;
            timeout <= 1'b1;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end else begin
            x_out <= x_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
